// File: rtl/uart_fifo_tx.sv
// uart_fifo_tx: byte-wide transmit FIFO feeding an 8-bit UART serializer.
// Frames are start(0), 8 data bits LSB first, optional parity, STOP_BITS stop(1).
// Ports:
//   clk           system clock, rising-edge
//   n_rst         asynchronous active-low reset
//   uart_in       byte to queue, taken when uart_in_valid && tx_ready
//   uart_in_valid write strobe
//   tx_ready      FIFO has room (from registered occupancy)
//   TxD           serial line, idle high, flop-driven
//   tx_busy       a frame is being shifted out
//   fifo_count    bytes waiting in the FIFO, not counting the one on the line
module uart_fifo_tx #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic [7:0]                    uart_in,
  input  logic                          uart_in_valid,
  output logic                          tx_ready,
  output logic                          TxD,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned DIV    = CLK_FREQ / BAUD_RATE;
  localparam int unsigned BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_e;

  state_e             state_q, state_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic               stop_q, stop_d;
  logic [7:0]         data_q, data_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               txd_q, txd_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;
  logic [7:0]         mem_q [FIFO_DEPTH];

  logic               push_c, pop_c, bit_done_c, fifo_nempty_c;

  // ready_q always equals (count_q < FIFO_DEPTH), so writes never bypass a full FIFO
  assign push_c        = uart_in_valid && ready_q;
  assign bit_done_c    = (baud_q == BAUD_W'(DIV - 1));
  assign fifo_nempty_c = (count_q != '0);

  // Storage array; pointers carry the reset, contents do not need one
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= uart_in;
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      stop_q    <= 1'b0;
      data_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      stop_q    <= stop_d;
      data_q    <= data_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
    end
  end

  // Next-state, pop decision and next line level
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    stop_d    = stop_q;
    data_d    = data_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    pop_c     = 1'b0;
    txd_d     = 1'b1;

    if (state_q != S_IDLE) begin
      baud_d = bit_done_c ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (fifo_nempty_c) begin
          pop_c   = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_done_c) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (bit_done_c) begin
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) begin
            state_d = PARITY_EN ? S_PARITY : S_STOP;
            stop_d  = 1'b0;
          end
        end
      end
      S_PARITY: begin
        if (bit_done_c) begin
          state_d = S_STOP;
          stop_d  = 1'b0;
        end
      end
      S_STOP: begin
        if (bit_done_c) begin
          if (stop_q == 1'(STOP_BITS - 1)) begin
            // back-to-back frames: reload straight into START when data waits
            if (fifo_nempty_c) begin
              pop_c   = 1'b1;
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop_c) begin
      data_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + 1'b1;
      baud_d   = '0;
    end
    if (push_c) wr_ptr_d = wr_ptr_q + 1'b1;

    case ({push_c, pop_c})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Line level is computed for the upcoming state so TxD changes on the same edge
    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = data_d[bit_idx_d];
      S_PARITY: txd_d = (^data_d) ^ PARITY_ODD;
      default:  txd_d = 1'b1;
    endcase
  end

  assign busy_d  = (state_d != S_IDLE);
  assign ready_d = (count_d < CNT_W'(FIFO_DEPTH));

  assign TxD        = txd_q;
  assign tx_busy    = busy_q;
  assign tx_ready   = ready_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Randomized scoreboard bench for uart_fifo_tx. The reference model predicts
// when each accepted byte starts on the line (FIFO order, back-to-back rule)
// and the expected level of every cycle of its frame.
module tb_uart_fifo_tx;

  localparam int unsigned CLK_FREQ = 1050;   // truncates to DIV = 10
  localparam int unsigned BAUD     = 100;
  localparam int unsigned DEPTH    = 8;
  localparam bit          PE       = 1'b1;
  localparam bit          ODD      = 1'b1;
  localparam int unsigned STOPS    = 2;
  localparam int unsigned DIV      = CLK_FREQ / BAUD;
  localparam int unsigned NBITS    = 1 + 8 + (PE ? 1 : 0) + STOPS;
  localparam longint      FRAME    = longint'(NBITS * DIV);

  logic                      clk = 1'b0;
  logic                      n_rst = 1'b0;
  logic [7:0]                uart_in = '0;
  logic                      uart_in_valid = 1'b0;
  logic                      tx_ready, TxD, tx_busy;
  logic [$clog2(DEPTH):0]    fifo_count;

  uart_fifo_tx #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .FIFO_DEPTH(DEPTH),
    .PARITY_EN(PE), .PARITY_ODD(ODD), .STOP_BITS(STOPS)
  ) dut (
    .clk(clk), .n_rst(n_rst), .uart_in(uart_in), .uart_in_valid(uart_in_valid),
    .tx_ready(tx_ready), .TxD(TxD), .tx_busy(tx_busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  longint cyc = 0;   // index of the most recent rising edge
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    longint     start;
  } exp_t;

  exp_t   sb[$];       // bytes accepted, not yet seen starting on the line
  longint sched[$];    // start edges of bytes still held in the FIFO
  longint last_end = 0;
  int     n_checks = 0;
  int     n_fail   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at edge %0d", name, act, exp, cyc);
    end
  endfunction

  function automatic logic exp_level(logic [7:0] d, longint j);
    int b;
    b = int'(j / longint'(DIV));
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (PE && b == 9) return (^d) ^ ODD;
    return 1'b1;
  endfunction

  // One cycle of stimulus: check occupancy, drive, predict acceptance
  task automatic step(input bit v, input logic [7:0] d);
    longint k;
    longint st;
    bit     exp_rdy;
    k = cyc;
    while (sched.size() > 0 && sched[0] <= k) void'(sched.pop_front());
    exp_rdy = (sched.size() < DEPTH);
    check("fifo_count", 32'(fifo_count), 32'(sched.size()));
    check("tx_ready", 32'(tx_ready), 32'(exp_rdy));
    uart_in_valid = v;
    uart_in       = d;
    if (v && exp_rdy) begin
      st = (k + 2 > last_end) ? k + 2 : last_end;
      sched.push_back(st);
      sb.push_back('{data: d, start: st});
      last_end = st + FRAME;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    while (cyc <= last_end + 2) step(1'b0, 8'h00);
  endtask

  // Monitor: detects frame starts on TxD and compares against the scoreboard
  initial begin
    bit         in_frame;
    longint     j;
    int         errs;
    exp_t       cur;
    logic [7:0] got;
    in_frame = 1'b0;
    j = 0; errs = 0; got = '0;
    cur = '{data: 8'h00, start: 0};
    forever begin
      @(posedge clk);
      #1;
      if (!n_rst) begin
        in_frame = 1'b0;
        continue;
      end
      if (!in_frame) begin
        if (TxD === 1'b0) begin
          check("start_has_expected_byte", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            cur = sb.pop_front();
            check("start_edge", 32'(cyc), 32'(cur.start));
            in_frame = 1'b1;
            j = 0; errs = 0; got = '0;
          end
        end else begin
          check("idle_busy", 32'(tx_busy), 32'd0);
        end
      end
      if (in_frame) begin
        if (TxD !== exp_level(cur.data, j) || tx_busy !== 1'b1) errs++;
        if (j / DIV >= 1 && j / DIV <= 8 && j % DIV == DIV / 2)
          got[int'(j / DIV) - 1] = TxD;
        j++;
        if (j == FRAME) begin
          check("frame_wave_errors", 32'(errs), 32'd0);
          check("frame_data", 32'(got), 32'(cur.data));
          in_frame = 1'b0;
        end
      end
    end
  end

  initial begin
    longint st0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_txd", 32'(TxD), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_ready", 32'(tx_ready), 32'd1);
    @(negedge clk) n_rst = 1'b1;
    @(posedge clk);
    #1;

    // Single byte from idle, then a quiet stretch
    step(1'b1, 8'h55);
    repeat (int'(FRAME) + 8) step(1'b0, 8'h00);

    // Two queued bytes: no gap between frames
    step(1'b1, 8'hA5);
    step(1'b1, 8'h3C);
    drain();

    // Parity and stop-bit patterns
    step(1'b1, 8'h07);
    step(1'b1, 8'hFF);
    step(1'b1, 8'h00);
    drain();

    // Ten consecutive writes from idle: ninth fills the FIFO, tenth dropped
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h10 + i));
    drain();

    // Random traffic: sparse first, then dense enough to hit full often
    for (int i = 0; i < 1200; i++) begin
      if (i < 500) step($urandom_range(0, 5) == 0, 8'($urandom));
      else         step($urandom_range(0, 3) != 0, 8'($urandom));
    end
    drain();

    // Reset in the middle of the data bits with bytes still queued
    step(1'b1, 8'hC3);
    st0 = sb[sb.size()-1].start;
    step(1'b1, 8'h5A);
    step(1'b1, 8'h96);
    step(1'b1, 8'h81);
    while (cyc < st0 + 3 * longint'(DIV) + 4) step(1'b0, 8'h00);
    uart_in_valid = 1'b0;
    #2;
    n_rst = 1'b0;
    #1;
    check("midrst_txd", 32'(TxD), 32'd1);
    check("midrst_busy", 32'(tx_busy), 32'd0);
    check("midrst_count", 32'(fifo_count), 32'd0);
    check("midrst_ready", 32'(tx_ready), 32'd1);
    sb.delete();
    sched.delete();
    last_end = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) n_rst = 1'b1;
    @(posedge clk);
    #1;
    repeat (3 * int'(FRAME)) step(1'b0, 8'h00);
    check("post_rst_line_idle", 32'(TxD), 32'd1);

    // Recovery after reset
    step(1'b1, 8'hE7);
    drain();

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_fifo_tx.md
UART_FIFO_TX -- requirements
Module: uart_fifo_tx

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115_200, line bit rate.
REQ-003 Parameter FIFO_DEPTH, default 8, power of two, minimum 2; transmit buffer entries.
REQ-004 Parameter PARITY_EN, default 0, 1 = insert a parity bit after the data bits.
REQ-005 Parameter PARITY_ODD, default 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
REQ-006 Parameter STOP_BITS, default 1, legal values 1 or 2.
REQ-007 clk  input  1  single system clock; all state updates on the rising edge.
REQ-008 n_rst  input  1  asynchronous, active-low reset.
REQ-009 uart_in  input  8  byte to transmit, sampled when uart_in_valid and tx_ready are both 1.
REQ-010 uart_in_valid  input  1  write strobe.
REQ-011 tx_ready  output  1  FIFO can accept a byte this cycle.
REQ-012 TxD  output  1  serial line, idle high, registered.
REQ-013 tx_busy  output  1  frame in progress.
REQ-014 fifo_count  output  $clog2(FIFO_DEPTH)+1  number of bytes held in the FIFO, excluding the byte being serialized.

Function
REQ-015 Bit period DIV = CLK_FREQ/BAUD_RATE, integer truncation (434 at defaults); every line bit SHALL last exactly DIV cycles.
REQ-016 Frame order: start bit (0), data bits LSB first, optional parity bit, then STOP_BITS stop bits (1).
REQ-017 Parity bit = XOR of the 8 data bits, inverted when PARITY_ODD=1.
REQ-018 FSM states: IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY_EN=0.
REQ-019 IDLE: when fifo_count != 0, pop the head byte into the shift register and move to START; otherwise stay in IDLE with TxD=1.
REQ-020 START/DATA/PARITY/STOP: advance after DIV cycles; DATA uses a 3-bit index 0..7; STOP counts STOP_BITS periods.
REQ-021 At the end of the last stop period, the FSM goes directly to START with a pop when the FIFO is non-empty (no idle gap), else to IDLE.
REQ-022 Latency: a byte accepted at edge N into an empty FIFO with the FSM in IDLE SHALL drive TxD=0 from edge N+1.
REQ-023 tx_ready = (fifo_count < FIFO_DEPTH), derived only from registered count; no same-cycle write-through.
REQ-024 A write while full is ignored; data is not corrupted, count is unchanged.
REQ-025 A push and a pop in the same cycle leave fifo_count unchanged; read/write pointers wrap modulo FIFO_DEPTH.
REQ-026 tx_busy = 1 in every state except IDLE.
REQ-027 TxD SHALL be driven from a flop (glitch-free).

Reset
REQ-028 n_rst low at any time, including mid-frame, SHALL immediately force: TxD=1, tx_busy=0, state IDLE, fifo_count=0, tx_ready=1, pointers and baud/bit counters=0; FIFO contents are discarded.
REQ-029 After n_rst deasserts, no frame starts until a new byte is written.

Verification
REQ-030 Default params, write 0x55 at edge N -> TxD=0 for edges N+1..N+434, then bits 1,0,1,0,1,0,1,0 at 434 cycles each, then 1; tx_busy falls 4340 cycles after N+1.
REQ-031 Push 10 bytes on consecutive cycles starting from idle -> first 9 accepted (one is popped at N+1), fifo_count reaches 8, tx_ready=0, 10th ignored; all 9 bytes appear on TxD in order.
REQ-032 Two bytes queued (0xA5, 0x3C) -> the stop bit of the first is followed immediately by the start bit of the second, with no extra high cycles.
REQ-033 PARITY_EN=1, PARITY_ODD=0, byte 0x07 -> parity bit 1; PARITY_ODD=1 -> parity bit 0; frame length is 11 bit periods.
REQ-034 STOP_BITS=2, byte 0xFF -> high lasts 2x434 cycles after the data before the next start.
REQ-035 n_rst pulsed low mid-DATA with 3 bytes queued -> TxD=1 the same cycle, fifo_count=0, no further frames.
